nabp_angle_sequencer: RTL and testbench
=======================================

# nabp_angle_sequencer

Parametrised successor to the combinational angle-to-mode decode. It sequences a programmed run of projection angles (start, step, count) and wraps at 180°. For each angle it issues one registered beat carrying the sector and the four scan/buffer mode bits over a valid/ready handshake. It sits between the top-level NABP FSM, which starts a run, and the line-buffer/scan datapath, which consumes one beat per projection. An optional sector-change flush stall is included.

## Interface
- ANGLE_WIDTH, 9: width of all angle quantities.
- ANGLE_180, 180: angle code equal to 180°; must be divisible by 4 and < 2^ANGLE_WIDTH. Sector thresholds are ANGLE_180/4, /2 and 3/4.
- COUNT_WIDTH, 10: width of the projection count.
- clk  in  1  single clock; one clock domain; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; accepted only in IDLE.
- angle_start  in  ANGLE_WIDTH  first angle; must be < ANGLE_180; sampled on the accepted start.
- angle_step  in  ANGLE_WIDTH  increment; must be < ANGLE_180; sampled on the accepted start.
- angle_count  in  COUNT_WIDTH  number of beats; sampled on the accepted start.
- out_valid  out  1  beat valid.
- out_ready  in  1  consumer accepts.
- angle  out  ANGLE_WIDTH  current angle.
- sector  out  2  a=0 [0,45°), b=1 [45,90°), c=2 [90,135°), d=3 [135,180°).
- scan_mode  out  1  x=0 in sectors a,d; y=1 otherwise.
- scan_direction  out  1  forward=0 in sectors a,b; backward=1 otherwise.
- buff_step_mode  out  1  tan=0 in sectors a,d; cot=1 otherwise.
- buff_step_direction  out  1  ascending=0 in sector a; descending=1 otherwise.
- first / last  out  1  beat is the first / last of the run.
- sector_change  out  1  beat's sector differs from the previous beat's; always 0 on the first beat.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse at end of run.
- flush_req  out  1  present only with the macro.
- flush_ack  in  1  present only with the macro.

## Operation
- States: IDLE, RUN, FLUSH (macro only), FINISH.
- IDLE: on start with angle_count≠0, latch the inputs, load angle=angle_start and remaining=angle_count, then go to RUN. On start with angle_count=0, go directly to FINISH. start in any other state is ignored.
- RUN: out_valid=1. Payload and flags stay stable until out_valid&&out_ready.
- On transfer with last=1: go to FINISH.
- On transfer otherwise: angle ← (angle+angle_step ≥ ANGLE_180) ? angle+angle_step−ANGLE_180 : angle+angle_step. The sum is computed at ANGLE_WIDTH+1 bits. remaining decrements. Mode bits are recomputed from the new angle and registered with it.
- FINISH: done=1 for one cycle, then IDLE.
- Output register values in IDLE and FINISH are don't-care except out_valid=0.
- reset from any state: state=IDLE and all outputs 0, including angle/sector. Any in-flight run is abandoned and done is not pulsed.

## Timing
- start accepted at edge N: first beat is valid from cycle N+1.
- Zero-stall throughput: one beat per cycle.
- Last beat transferred at edge M: done=1 in cycle M+1; busy drops and the next start is accepted from cycle M+2.
- angle_count=0: done=1 in cycle N+1 with no beat issued.
- The decode path is combinational from the next-angle value into registers, so no extra latency is added.

## Configuration
- NABP_SECTOR_FLUSH_EN defined:
  - On a transfer whose next beat will have sector_change=1, the block enters FLUSH.
  - In FLUSH: out_valid=0 and flush_req=1 until flush_ack is sampled high.
  - The next beat is valid in the cycle after the ack.
  - flush_ack outside FLUSH is ignored.
  - reset in FLUSH drops flush_req in the next cycle.
- Undefined: no FLUSH state and no flush ports; sector_change is informational only and the block never stalls.

## Structure
- Package nabp_mode_pkg holds:
  - enum typedefs sector_t, scan_mode_t, scan_direction_t, buff_step_mode_t, buff_step_direction_t, with the encodings above;
  - state_t;
  - localparams for the sector thresholds.
- Sub-module nabp_sector_decode is purely combinational: angle in, sector and four mode bits out, parametrised on ANGLE_WIDTH and ANGLE_180. It is instantiated once, on the next-angle path.

## Test plan
- start, angle_start=0, step=15, count=12, out_ready=1 → angles 0,15,…,165 on 12 consecutive cycles; sector_change=1 at 45, 90 and 135; last at 165; done one cycle later.
- angle_start=170, step=20, count=3 → angles 170, 10, 30; sectors d, a, a; sector_change=1 on the angle-10 beat only.
- angle_start=44, step=1, count=4, out_ready toggled every cycle → 4 beats, payload stable while stalled, none lost or duplicated.
- count=0 → no out_valid; done=1 exactly at N+1. A start issued while busy has no effect.
- reset asserted mid-run (third beat) → out_valid, busy and done all 0 next cycle; a fresh start runs normally.
- NABP_SECTOR_FLUSH_EN, start=40, step=5, count=3, flush_ack delayed 3 cycles → beats 40, then flush_req held 3 cycles, then 45 (sector b) the cycle after ack, then 50.

Source files
------------

// File: rtl/nabp_mode_pkg.sv
// Shared types for the NABP angle sequencer: sector/mode encodings, FSM states
// and sector threshold positions expressed in quarters of the 180-degree code.
package nabp_mode_pkg;

    localparam int unsigned ANGLE_180_DEFAULT = 180;

    // Sector boundaries as multiples of ANGLE_180/4
    localparam int unsigned SECTOR_B_QUARTERS = 1;
    localparam int unsigned SECTOR_C_QUARTERS = 2;
    localparam int unsigned SECTOR_D_QUARTERS = 3;

    typedef enum logic [1:0] {
        SECTOR_A = 2'd0,
        SECTOR_B = 2'd1,
        SECTOR_C = 2'd2,
        SECTOR_D = 2'd3
    } sector_t;

    typedef enum logic {
        SCAN_X = 1'b0,
        SCAN_Y = 1'b1
    } scan_mode_t;

    typedef enum logic {
        SCAN_FORWARD  = 1'b0,
        SCAN_BACKWARD = 1'b1
    } scan_direction_t;

    typedef enum logic {
        BUFF_STEP_TAN = 1'b0,
        BUFF_STEP_COT = 1'b1
    } buff_step_mode_t;

    typedef enum logic {
        BUFF_STEP_ASCENDING  = 1'b0,
        BUFF_STEP_DESCENDING = 1'b1
    } buff_step_direction_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/nabp_sector_decode.sv
// Combinational angle-to-sector decode producing the four scan/buffer mode bits.
module nabp_sector_decode
    import nabp_mode_pkg::*;
#(
    parameter int unsigned ANGLE_WIDTH = 9,
    parameter int unsigned ANGLE_180   = ANGLE_180_DEFAULT
) (
    input  logic [ANGLE_WIDTH-1:0] angle_i,
    output sector_t                sector_o,
    output scan_mode_t             scan_mode_o,
    output scan_direction_t        scan_direction_o,
    output buff_step_mode_t        buff_step_mode_o,
    output buff_step_direction_t   buff_step_direction_o
);

    localparam logic [ANGLE_WIDTH-1:0] TH_B = ANGLE_WIDTH'((ANGLE_180 * SECTOR_B_QUARTERS) / 4);
    localparam logic [ANGLE_WIDTH-1:0] TH_C = ANGLE_WIDTH'((ANGLE_180 * SECTOR_C_QUARTERS) / 4);
    localparam logic [ANGLE_WIDTH-1:0] TH_D = ANGLE_WIDTH'((ANGLE_180 * SECTOR_D_QUARTERS) / 4);

    always_comb begin
        sector_o = SECTOR_D;
        if (angle_i < TH_B) begin
            sector_o = SECTOR_A;
        end else if (angle_i < TH_C) begin
            sector_o = SECTOR_B;
        end else if (angle_i < TH_D) begin
            sector_o = SECTOR_C;
        end
    end

    always_comb begin
        scan_mode_o           = SCAN_X;
        scan_direction_o      = SCAN_BACKWARD;
        buff_step_mode_o      = BUFF_STEP_TAN;
        buff_step_direction_o = BUFF_STEP_DESCENDING;
        if (sector_o == SECTOR_B || sector_o == SECTOR_C) begin
            scan_mode_o      = SCAN_Y;
            buff_step_mode_o = BUFF_STEP_COT;
        end
        if (sector_o == SECTOR_A || sector_o == SECTOR_B) begin
            scan_direction_o = SCAN_FORWARD;
        end
        if (sector_o == SECTOR_A) begin
            buff_step_direction_o = BUFF_STEP_ASCENDING;
        end
    end

endmodule

// File: rtl/nabp_angle_sequencer.sv
// Sequences a run of projection angles (start, step, count) wrapping at 180 degrees,
// one registered sector/mode beat per angle. NABP_SECTOR_FLUSH_EN adds a flush stall.
module nabp_angle_sequencer
    import nabp_mode_pkg::*;
#(
    parameter int unsigned ANGLE_WIDTH = 9,
    parameter int unsigned ANGLE_180   = ANGLE_180_DEFAULT,
    parameter int unsigned COUNT_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ANGLE_WIDTH-1:0] angle_start,
    input  logic [ANGLE_WIDTH-1:0] angle_step,
    input  logic [COUNT_WIDTH-1:0] angle_count,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ANGLE_WIDTH-1:0] angle,
    output logic [1:0]             sector,
    output logic                   scan_mode,
    output logic                   scan_direction,
    output logic                   buff_step_mode,
    output logic                   buff_step_direction,
    output logic                   first,
    output logic                   last,
    output logic                   sector_change,
`ifdef NABP_SECTOR_FLUSH_EN
    output logic                   flush_req,
    input  logic                   flush_ack,
`endif
    output logic                   busy,
    output logic                   done
);

    localparam logic [ANGLE_WIDTH:0] A180_W = (ANGLE_WIDTH+1)'(ANGLE_180);

    state_t                 state_q, state_d;
    logic [ANGLE_WIDTH-1:0] angle_q, angle_d;
    logic [ANGLE_WIDTH-1:0] step_q, step_d;
    logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
    logic                   first_q, first_d;
    logic                   last_q, last_d;
    logic                   sc_q, sc_d;
    sector_t                sector_q, sector_d;
    scan_mode_t             scan_mode_q, scan_mode_d;
    scan_direction_t        scan_dir_q, scan_dir_d;
    buff_step_mode_t        buff_mode_q, buff_mode_d;
    buff_step_direction_t   buff_dir_q, buff_dir_d;

    sector_t                dec_sector;
    scan_mode_t             dec_scan_mode;
    scan_direction_t        dec_scan_dir;
    buff_step_mode_t        dec_buff_mode;
    buff_step_direction_t   dec_buff_dir;

    logic [ANGLE_WIDTH:0]   sum_w;
    logic [ANGLE_WIDTH-1:0] next_angle_w;
    logic                   load_beat;

    assign sum_w        = {1'b0, angle_q} + {1'b0, step_q};
    assign next_angle_w = (sum_w >= A180_W) ? ANGLE_WIDTH'(sum_w - A180_W) : sum_w[ANGLE_WIDTH-1:0];

    // Decode sits on angle_d so mode bits are registered alongside the angle
    nabp_sector_decode #(
        .ANGLE_WIDTH (ANGLE_WIDTH),
        .ANGLE_180   (ANGLE_180)
    ) u_decode (
        .angle_i               (angle_d),
        .sector_o              (dec_sector),
        .scan_mode_o           (dec_scan_mode),
        .scan_direction_o      (dec_scan_dir),
        .buff_step_mode_o      (dec_buff_mode),
        .buff_step_direction_o (dec_buff_dir)
    );

    always_comb begin
        state_d     = state_q;
        angle_d     = angle_q;
        step_d      = step_q;
        remaining_d = remaining_q;
        first_d     = first_q;
        last_d      = last_q;
        sc_d        = sc_q;
        load_beat   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (angle_count != '0) begin
                        state_d     = ST_RUN;
                        angle_d     = angle_start;
                        step_d      = angle_step;
                        remaining_d = angle_count;
                        first_d     = 1'b1;
                        last_d      = (angle_count == COUNT_WIDTH'(1));
                        sc_d        = 1'b0;
                        load_beat   = 1'b1;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_RUN: begin
                if (out_ready) begin
                    if (last_q) begin
                        state_d = ST_FINISH;
                    end else begin
                        angle_d     = next_angle_w;
                        remaining_d = remaining_q - COUNT_WIDTH'(1);
                        first_d     = 1'b0;
                        last_d      = (remaining_q == COUNT_WIDTH'(2));
                        sc_d        = (dec_sector != sector_q);
                        load_beat   = 1'b1;
`ifdef NABP_SECTOR_FLUSH_EN
                        if (dec_sector != sector_q) begin
                            state_d = ST_FLUSH;
                        end
`endif
                    end
                end
            end
            ST_FLUSH: begin
`ifdef NABP_SECTOR_FLUSH_EN
                if (flush_ack) begin
                    state_d = ST_RUN;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sector_d    = sector_q;
        scan_mode_d = scan_mode_q;
        scan_dir_d  = scan_dir_q;
        buff_mode_d = buff_mode_q;
        buff_dir_d  = buff_dir_q;
        if (load_beat) begin
            sector_d    = dec_sector;
            scan_mode_d = dec_scan_mode;
            scan_dir_d  = dec_scan_dir;
            buff_mode_d = dec_buff_mode;
            buff_dir_d  = dec_buff_dir;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            angle_q     <= '0;
            step_q      <= '0;
            remaining_q <= '0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            sc_q        <= 1'b0;
            sector_q    <= SECTOR_A;
            scan_mode_q <= SCAN_X;
            scan_dir_q  <= SCAN_FORWARD;
            buff_mode_q <= BUFF_STEP_TAN;
            buff_dir_q  <= BUFF_STEP_ASCENDING;
        end else begin
            state_q     <= state_d;
            angle_q     <= angle_d;
            step_q      <= step_d;
            remaining_q <= remaining_d;
            first_q     <= first_d;
            last_q      <= last_d;
            sc_q        <= sc_d;
            sector_q    <= sector_d;
            scan_mode_q <= scan_mode_d;
            scan_dir_q  <= scan_dir_d;
            buff_mode_q <= buff_mode_d;
            buff_dir_q  <= buff_dir_d;
        end
    end

    assign out_valid           = (state_q == ST_RUN);
    assign busy                = (state_q != ST_IDLE);
    assign done                = (state_q == ST_FINISH);
    assign angle               = angle_q;
    assign sector              = sector_q;
    assign scan_mode           = scan_mode_q;
    assign scan_direction      = scan_dir_q;
    assign buff_step_mode      = buff_mode_q;
    assign buff_step_direction = buff_dir_q;
    assign first               = first_q;
    assign last                = last_q;
    assign sector_change       = sc_q;
`ifdef NABP_SECTOR_FLUSH_EN
    assign flush_req           = (state_q == ST_FLUSH);
`endif

endmodule

// File: tb/tb_nabp_angle_sequencer.sv
// Scoreboard bench for nabp_angle_sequencer; honours NABP_SECTOR_FLUSH_EN when defined.
`timescale 1ns/1ps
module tb_nabp_angle_sequencer;

    localparam int AW = 9;
    localparam int CW = 10;
`ifdef NABP_SECTOR_FLUSH_EN
    localparam int FL = 3;
`else
    localparam int FL = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          out_ready = 1'b1;
    logic [AW-1:0] angle_start = '0;
    logic [AW-1:0] angle_step = '0;
    logic [CW-1:0] angle_count = '0;
    logic          out_valid, busy, done, first, last, sector_change;
    logic [AW-1:0] angle;
    logic [1:0]    sector;
    logic          scan_mode, scan_direction, buff_step_mode, buff_step_direction;
`ifdef NABP_SECTOR_FLUSH_EN
    logic          flush_req;
    logic          flush_ack = 1'b0;
    int            fr_run = 0;
    int            fr_max = 0;
`endif

    nabp_angle_sequencer #(
        .ANGLE_WIDTH (AW),
        .ANGLE_180   (180),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .angle_start         (angle_start),
        .angle_step          (angle_step),
        .angle_count         (angle_count),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .angle               (angle),
        .sector              (sector),
        .scan_mode           (scan_mode),
        .scan_direction      (scan_direction),
        .buff_step_mode      (buff_step_mode),
        .buff_step_direction (buff_step_direction),
        .first               (first),
        .last                (last),
        .sector_change       (sector_change),
`ifdef NABP_SECTOR_FLUSH_EN
        .flush_req           (flush_req),
        .flush_ack           (flush_ack),
`endif
        .busy                (busy),
        .done                (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] angle;
        logic [1:0]    sector;
        logic          first;
        logic          last;
        logic          sc;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    failures = 0;
    logic  toggle_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // {scan_mode, scan_direction, buff_step_mode, buff_step_direction} per sector
    function automatic logic [3:0] modes(input logic [1:0] s);
        case (s)
            2'd0:    return 4'b0000;
            2'd1:    return 4'b1011;
            2'd2:    return 4'b1111;
            default: return 4'b0101;
        endcase
    endfunction

    task automatic push(input int a, input int s, input bit f, input bit l, input bit sc);
        beat_t b;
        b.angle  = AW'(a);
        b.sector = 2'(s);
        b.first  = f;
        b.last   = l;
        b.sc     = sc;
        exp_q.push_back(b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int a, input int s, input int c);
        angle_start = AW'(a);
        angle_step  = AW'(s);
        angle_count = CW'(c);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        logic  stall_prev = 1'b0;
        logic [AW-1:0] stall_angle = '0;
        beat_t b;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (stall_prev) chk("stall_stable", 32'(angle), 32'(stall_angle));
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 32'(angle), 32'hFFFF_FFFF);
                    end else begin
                        b = exp_q.pop_front();
                        chk("beat_angle", 32'(angle), 32'(b.angle));
                        chk("beat_sector", 32'(sector), 32'(b.sector));
                        chk("beat_modes", 32'({scan_mode, scan_direction, buff_step_mode, buff_step_direction}),
                            32'(modes(b.sector)));
                        chk("beat_first", 32'(first), 32'(b.first));
                        chk("beat_last", 32'(last), 32'(b.last));
                        chk("beat_sector_change", 32'(sector_change), 32'(b.sc));
                    end
                end
                stall_prev  = !out_ready;
                stall_angle = angle;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            tick();
            if (toggle_en) out_ready = ~out_ready;
        end
    end

`ifdef NABP_SECTOR_FLUSH_EN
    initial begin
        forever begin
            @(negedge clk);
            if (flush_req === 1'b1) begin
                fr_run++;
                if (fr_run > fr_max) fr_max = fr_run;
                if (fr_run >= 3) flush_ack = 1'b1;
            end else begin
                fr_run    = 0;
                flush_ack = 1'b0;
            end
        end
    end
`endif

    initial begin
        int cyc;
        repeat (3) tick();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_angle", 32'(angle), 0);
        chk("rst_sector", 32'(sector), 0);
        reset = 1'b0;
        tick();

        // 0..165 step 15, full throughput
        for (int i = 0; i < 12; i++) push(i * 15, i / 3, i == 0, i == 11, i == 3 || i == 6 || i == 9);
        launch(0, 15, 12);
        chk("t1_busy", 32'(busy), 1);
        wait_done(cyc);
        chk("t1_done_cycle", 32'(cyc), 32'(12 + 3 * FL));
        tick();
        chk("t1_done_pulse", 32'(done), 0);
        chk("t1_idle", 32'(busy), 0);

        // wrap through 180
        push(170, 3, 1, 0, 0);
        push(10, 0, 0, 0, 1);
        push(30, 0, 0, 1, 0);
        launch(170, 20, 3);
        wait_done(cyc);
        chk("t2_done_cycle", 32'(cyc), 32'(3 + FL));
        tick();

        // back-pressure across the 45-degree boundary
        push(44, 0, 1, 0, 0);
        push(45, 1, 0, 0, 1);
        push(46, 1, 0, 0, 0);
        push(47, 1, 0, 1, 0);
        out_ready = 1'b0;
        toggle_en = 1'b1;
        launch(44, 1, 4);
        wait_done(cyc);
        chk("t3_done_seen", 32'(done), 1);
        toggle_en = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();

        // zero-length run
        launch(10, 10, 0);
        chk("t4_done_n1", 32'(done), 1);
        chk("t4_no_valid", 32'(out_valid), 0);
        tick();
        chk("t4_done_once", 32'(done), 0);
        chk("t4_idle", 32'(busy), 0);

        // start while busy is ignored
        push(0, 0, 1, 0, 0);
        push(10, 0, 0, 0, 0);
        push(20, 0, 0, 1, 0);
        launch(0, 10, 3);
        tick();
        angle_start = AW'(100);
        angle_count = CW'(2);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc);
        chk("t5_done_cycle", 32'(cyc), 1);
        tick();
        tick();

        // reset during the third beat
        push(0, 0, 1, 0, 0);
        push(15, 0, 0, 0, 0);
        push(30, 0, 0, 0, 0);
        launch(0, 15, 12);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_valid", 32'(out_valid), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_done", 32'(done), 0);
        chk("t6_angle", 32'(angle), 0);
        chk("t6_sector", 32'(sector), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_no_done", 32'(done), 0);
        end

        // fresh run after the abort
        push(170, 3, 1, 0, 0);
        push(10, 0, 0, 0, 1);
        push(30, 0, 0, 1, 0);
        launch(170, 20, 3);
        wait_done(cyc);
        chk("t7_done_cycle", 32'(cyc), 32'(3 + FL));
        tick();

`ifdef NABP_SECTOR_FLUSH_EN
        fr_max = 0;
        push(40, 0, 1, 0, 0);
        push(45, 1, 0, 0, 1);
        push(50, 1, 0, 1, 0);
        launch(40, 5, 3);
        wait_done(cyc);
        chk("t8_done_cycle", 32'(cyc), 32'(3 + FL));
        chk("t8_flush_len", 32'(fr_max), 3);
        tick();
`endif

        tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
